// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use detection,
// multi-cycle EX sequencing and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MULTI_LAT = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_reg_read_en_1,
  input  logic             id_reg_read_en_2,
  input  logic [4:0]       id_reg_addr_1,
  input  logic [4:0]       id_reg_addr_2,
  input  logic             id_write_reg_en,
  input  logic [4:0]       id_write_reg_addr,
  input  logic             id_is_load,
  input  logic             id_is_multi,
  input  logic             if_stall_req,
  input  logic             flush_req,
  output logic [4:0]       stall,
  output logic             flush,
  output logic             ex_busy,
  output logic             ex_done,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  localparam logic [3:0] RELOAD = 4'(MULTI_LAT - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ld_vld_q, ld_vld_d;
  logic [4:0]       ld_addr_q, ld_addr_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;

  logic       load_use;
  logic       busy_w;
  logic       done_w;
  logic       issue;
  logic [4:0] raw_stall;

  always_comb begin
    load_use = ld_vld_q &&
      ((id_reg_read_en_1 && (id_reg_addr_1 == ld_addr_q)) ||
       (id_reg_read_en_2 && (id_reg_addr_2 == ld_addr_q)));
    busy_w = (state_q == BUSY) && (cnt_q != 4'd0);
    done_w = (state_q == BUSY) && (cnt_q == 4'd0);

    // Stall codes nest, so OR-ing keeps the strongest.
    raw_stall = 5'b00000;
    if (if_stall_req) raw_stall = raw_stall | 5'b00001;
    if (load_use)     raw_stall = raw_stall | 5'b00011;
    if (busy_w)       raw_stall = raw_stall | 5'b00111;

    stall   = (rst || flush_req) ? 5'b00000 : raw_stall;
    flush   = !rst && flush_req;
    ex_busy = busy_w;
    ex_done = done_w;
    issue   = !flush_req && !stall[2] && !stall[1];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_vld_d  = ld_vld_q;
    ld_addr_d = ld_addr_q;
    scnt_d    = scnt_q;

    if (flush_req) begin
      state_d  = IDLE;
      cnt_d    = 4'd0;
      ld_vld_d = 1'b0;
    end else begin
      if (stall[2]) begin
        ld_vld_d = ld_vld_q;
      end else if (stall[1]) begin
        ld_vld_d = 1'b0;
      end else begin
        ld_vld_d  = id_is_load && id_write_reg_en &&
                    (id_write_reg_addr != 5'd0);
        ld_addr_d = id_write_reg_addr;
      end

      unique case (state_q)
        IDLE: begin
          if (issue && id_is_multi) begin
            state_d = BUSY;
            cnt_d   = RELOAD;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else if (issue && id_is_multi) begin
            cnt_d = RELOAD;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if ((stall != 5'b00000) && (scnt_q != {CNT_W{1'b1}}))
      scnt_d = scnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      ld_vld_q  <= 1'b0;
      ld_addr_q <= 5'd0;
      scnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_vld_q  <= ld_vld_d;
      ld_addr_q <= ld_addr_d;
      scnt_q    <= scnt_d;
    end
  end

  assign stall_cycles = scnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazards, multi-cycle EX, flush,
// async reset and counter saturation with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  localparam int CW = 5;

  logic          clk;
  logic          rst;
  logic          re1, re2;
  logic [4:0]    a1, a2;
  logic          we;
  logic [4:0]    wa;
  logic          is_ld, is_mul;
  logic          if_st, fl_req;
  logic [4:0]    stall;
  logic          flush, busy, done;
  logic [CW-1:0] sc;

  int n_run;
  int n_fail;

  pipe_hazard_ctrl #(.MULTI_LAT(4), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_reg_read_en_1 (re1),
    .id_reg_read_en_2 (re2),
    .id_reg_addr_1    (a1),
    .id_reg_addr_2    (a2),
    .id_write_reg_en  (we),
    .id_write_reg_addr(wa),
    .id_is_load       (is_ld),
    .id_is_multi      (is_mul),
    .if_stall_req     (if_st),
    .flush_req        (fl_req),
    .stall            (stall),
    .flush            (flush),
    .ex_busy          (busy),
    .ex_done          (done),
    .stall_cycles     (sc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr();
    re1 = 0; re2 = 0; a1 = 0; a2 = 0;
    we = 0; wa = 0; is_ld = 0; is_mul = 0;
    if_st = 0; fl_req = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic load_of(input logic [4:0] r);
    clr(); is_ld = 1; we = 1; wa = r;
  endtask

  task automatic test_reset();
    rst = 1;
    clr(); if_st = 1; fl_req = 1; is_mul = 1;
    tick(); tick(); mid();
    n_run++; if (stall !== 5'b0) begin n_fail++; $display("FAIL rst_stall got %b want %b", stall, 5'b0); end
    n_run++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush got %b want 0", flush); end
    n_run++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_busy_done got %b%b want 00", busy, done); end
    n_run++; if (sc !== 5'd0) begin n_fail++; $display("FAIL rst_sc got %0d want 0", sc); end
    tick(); clr(); rst = 0;
  endtask

  task automatic test_load_use();
    load_of(5); mid();
    n_run++; if (stall !== 5'b00000) begin n_fail++; $display("FAIL lu_issue got %b want 00000", stall); end
    tick(); clr(); re2 = 1; a2 = 5; mid();
    n_run++; if (stall !== 5'b00011) begin n_fail++; $display("FAIL lu_hit2 got %b want 00011", stall); end
    tick(); mid();
    n_run++; if (stall !== 5'b00000) begin n_fail++; $display("FAIL lu_once got %b want 00000", stall); end
    n_run++; if (sc !== 5'd1) begin n_fail++; $display("FAIL lu_sc got %0d want 1", sc); end
    tick();
  endtask

  task automatic test_zero_reg();
    load_of(0); tick();
    clr(); re1 = 1; re2 = 1; mid();
    n_run++; if (stall !== 5'b00000) begin n_fail++; $display("FAIL r0_nohaz got %b want 00000", stall); end
    tick(); load_of(7); tick();
    clr(); re1 = 1; a1 = 7; mid();
    n_run++; if (stall !== 5'b00011) begin n_fail++; $display("FAIL lu_hit1 got %b want 00011", stall); end
    tick(); load_of(9); re1 = 1; a1 = 7; mid();
    n_run++; if (stall !== 5'b00000) begin n_fail++; $display("FAIL lu_bubble got %b want 00000", stall); end
    tick(); clr(); re1 = 1; a1 = 10; a2 = 9; mid();
    n_run++; if (stall !== 5'b00000) begin n_fail++; $display("FAIL lu_miss got %b want 00000", stall); end
    n_run++; if (sc !== 5'd2) begin n_fail++; $display("FAIL r0_sc got %0d want 2", sc); end
    tick(); clr();
  endtask

  task automatic test_multi();
    clr(); is_mul = 1; mid();
    n_run++; if (stall !== 5'b00000 || busy !== 1'b0) begin n_fail++; $display("FAIL mul_issue got %b/%b want 00000/0", stall, busy); end
    tick(); clr();
    for (int i = 0; i < 3; i++) begin
      mid();
      n_run++; if (stall !== 5'b00111 || busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL mul_busy%0d got %b/%b/%b want 00111/1/0", i, stall, busy, done); end
      tick();
    end
    mid();
    n_run++; if (stall !== 5'b00000 || busy !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL mul_done got %b/%b/%b want 00000/0/1", stall, busy, done); end
    n_run++; if (sc !== 5'd5) begin n_fail++; $display("FAIL mul_sc got %0d want 5", sc); end
    tick(); mid();
    n_run++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mul_pulse got %b%b want 00", busy, done); end
    tick();
  endtask

  task automatic test_flush();
    clr(); is_mul = 1; tick();
    clr(); tick();
    fl_req = 1; if_st = 1; mid();
    n_run++; if (flush !== 1'b1 || stall !== 5'b00000) begin n_fail++; $display("FAIL fl_prio got %b/%b want 1/00000", flush, stall); end
    tick(); clr();
    for (int i = 0; i < 3; i++) begin
      mid();
      n_run++; if (busy !== 1'b0 || done !== 1'b0 || stall !== 5'b0) begin n_fail++; $display("FAIL fl_abort%0d got %b/%b/%b want 0/0/00000", i, busy, done, stall); end
      tick();
    end
    load_of(5); tick();
    clr(); fl_req = 1; re2 = 1; a2 = 5; tick();
    clr(); re2 = 1; a2 = 5; mid();
    n_run++; if (stall !== 5'b00000) begin n_fail++; $display("FAIL fl_ldclr got %b want 00000", stall); end
    n_run++; if (sc !== 5'd6) begin n_fail++; $display("FAIL fl_sc got %0d want 6", sc); end
    tick(); clr();
  endtask

  task automatic test_flush_on_done();
    clr(); is_mul = 1; tick();
    clr(); tick(); tick(); tick();
    fl_req = 1; mid();
    n_run++; if (done !== 1'b1 || flush !== 1'b1) begin n_fail++; $display("FAIL fd_pulse got %b%b want 11", done, flush); end
    tick(); clr(); mid();
    n_run++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL fd_idle got %b%b want 00", busy, done); end
    tick();
  endtask

  task automatic test_back_to_back();
    clr(); is_mul = 1; tick();
    clr(); tick(); tick(); tick();
    is_mul = 1; mid();
    n_run++; if (done !== 1'b1 || stall !== 5'b00000) begin n_fail++; $display("FAIL b2b_done got %b/%b want 1/00000", done, stall); end
    tick(); clr();
    for (int i = 0; i < 3; i++) begin
      mid();
      n_run++; if (stall !== 5'b00111 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy%0d got %b/%b want 00111/1", i, stall, busy); end
      tick();
    end
    mid();
    n_run++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done2 got %b want 1", done); end
    n_run++; if (sc !== 5'd15) begin n_fail++; $display("FAIL b2b_sc got %0d want 15", sc); end
    tick();
  endtask

  task automatic test_if_stall();
    load_of(3); tick();
    clr(); re1 = 1; a1 = 3; if_st = 1; mid();
    n_run++; if (stall !== 5'b00011) begin n_fail++; $display("FAIL ifs_lu got %b want 00011", stall); end
    tick(); load_of(4); if_st = 1; mid();
    n_run++; if (stall !== 5'b00001) begin n_fail++; $display("FAIL ifs_only got %b want 00001", stall); end
    tick(); clr(); re2 = 1; a2 = 4; mid();
    n_run++; if (stall !== 5'b00011) begin n_fail++; $display("FAIL ifs_adv got %b want 00011", stall); end
    tick(); clr(); mid();
    n_run++; if (sc !== 5'd18) begin n_fail++; $display("FAIL ifs_sc got %0d want 18", sc); end
    tick();
  endtask

  task automatic test_async_reset();
    clr(); is_mul = 1; tick();
    clr(); tick();
    #1 rst = 1; if_st = 1;
    #1;
    n_run++; if (stall !== 5'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ar_now got %b/%b want 00000/0", stall, busy); end
    n_run++; if (sc !== 5'd0) begin n_fail++; $display("FAIL ar_sc got %0d want 0", sc); end
    tick(); clr(); rst = 0;
    for (int i = 0; i < 4; i++) begin
      mid();
      n_run++; if (stall !== 5'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL ar_run%0d got %b/%b/%b want 00000/0/0", i, stall, busy, done); end
      tick();
    end
    n_run++; if (sc !== 5'd0) begin n_fail++; $display("FAIL ar_sc2 got %0d want 0", sc); end
  endtask

  task automatic test_saturate();
    clr(); if_st = 1;
    for (int i = 0; i < 40; i++) tick();
    mid();
    n_run++; if (sc !== 5'd31) begin n_fail++; $display("FAIL sat_cnt got %0d want 31", sc); end
    tick(); clr();
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    rst = 1;
    clr();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_multi();
    test_flush();
    test_flush_on_done();
    test_back_to_back();
    test_if_stall();
    test_async_reset();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
